// File: rtl/intr_controller.sv
// intr_controller: N-line vectored interrupt controller with per-line enable,
// edge/level mode, fixed priority (index 0 highest) and nesting through an
// in-service register. One vector is presented to the CPU over a req/ack
// handshake; handlers are retired lowest-index-first on an EOI strobe.
module intr_controller #(
    parameter int unsigned        N_IRQ     = 8,
    parameter int unsigned        VEC_W     = 3,
    parameter logic [N_IRQ-1:0]   EDGE_MASK = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IRQ-1:0]  irq_in,
    input  logic              en_wr,
    input  logic [N_IRQ-1:0]  en_din,
    input  logic              irq_ack,
    input  logic              eoi,
    output logic              irq_req,
    output logic [VEC_W-1:0]  irq_vec,
    output logic [N_IRQ-1:0]  pending,
    output logic [N_IRQ-1:0]  in_service
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    localparam logic [N_IRQ-1:0] One = N_IRQ'(1);

    state_e             state_q, state_d;
    logic [N_IRQ-1:0]   irq_prev_q;
    logic [N_IRQ-1:0]   pending_q, pending_d;
    logic [N_IRQ-1:0]   in_service_q, in_service_d;
    logic [N_IRQ-1:0]   enable_q, enable_d;
    logic [VEC_W-1:0]   vec_q, vec_d;

    logic [N_IRQ-1:0]   set_req;
    logic [N_IRQ-1:0]   candidates;
    logic [N_IRQ-1:0]   isr_lowest;
    logic [N_IRQ-1:0]   preempt_mask;
    logic [N_IRQ-1:0]   eligible;
    logic [N_IRQ-1:0]   ack_onehot;
    logic [N_IRQ-1:0]   eoi_clear;
    logic               ack_fire;

    // Two's-complement trick: x & -x keeps only the lowest set bit.
    function automatic logic [N_IRQ-1:0] lowest_bit(input logic [N_IRQ-1:0] x);
        return x & (~x + One);
    endfunction

    // One-hot to index; OR-reduction keeps this a flat encoder.
    function automatic logic [VEC_W-1:0] encode(input logic [N_IRQ-1:0] onehot);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(N_IRQ); i++) begin
            if (onehot[i]) begin
                idx = idx | VEC_W'(i);
            end
        end
        return idx;
    endfunction

    // Source detection: rising edge for edge lines, every high cycle for level lines.
    always_comb begin
        set_req = (irq_in & ~irq_prev_q & EDGE_MASK) | (irq_in & ~EDGE_MASK);
    end

    // Priority/preemption: only lines strictly above the active handler may request.
    always_comb begin
        candidates   = pending_q & enable_q;
        isr_lowest   = lowest_bit(in_service_q);
        preempt_mask = (in_service_q == '0) ? '1 : (isr_lowest - One);
        eligible     = candidates & preempt_mask;
    end

    // Handshake side effects on pending/in-service; EOI acts before the ack set.
    always_comb begin
        ack_fire     = (state_q == StReq) && irq_ack;
        ack_onehot   = ack_fire ? (One << vec_q) : '0;
        eoi_clear    = eoi ? isr_lowest : '0;
        pending_d    = (pending_q & ~ack_onehot) | set_req;
        in_service_d = (in_service_q & ~eoi_clear) | ack_onehot;
        enable_d     = en_wr ? en_din : enable_q;
    end

    // FSM next state: latch the winning vector in idle, hold it until acked.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        unique case (state_q)
            StIdle: begin
                if (eligible != '0) begin
                    state_d = StReq;
                    vec_d   = encode(lowest_bit(eligible));
                end
            end
            StReq: begin
                if (irq_ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            irq_prev_q   <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            enable_q     <= '0;
            vec_q        <= '0;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq_in;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            enable_q     <= enable_d;
            vec_q        <= vec_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        irq_req    = (state_q == StReq);
        irq_vec    = vec_q;
        pending    = pending_q;
        in_service = in_service_q;
    end

endmodule

// File: tb/tb_intr_controller.sv
// Bench for intr_controller: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an index-level model.
module tb_intr_controller;

    localparam int unsigned    N        = 8;
    localparam int unsigned    W        = 3;
    localparam logic [N-1:0]   EdgeMask = 8'hF7;  // line 3 is level sensitive

    logic          clk;
    logic          reset;
    logic [N-1:0]  irq_in;
    logic          en_wr;
    logic [N-1:0]  en_din;
    logic          irq_ack;
    logic          eoi;
    logic          irq_req;
    logic [W-1:0]  irq_vec;
    logic [N-1:0]  pending;
    logic [N-1:0]  in_service;

    int checks = 0;
    int errors = 0;

    intr_controller #(
        .N_IRQ     (N),
        .VEC_W     (W),
        .EDGE_MASK (EdgeMask)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .en_wr      (en_wr),
        .en_din     (en_din),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec),
        .pending    (pending),
        .in_service (in_service)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [N-1:0] prev;
        logic [N-1:0] pend;
        logic [N-1:0] isr;
        logic [N-1:0] en;
        logic         req;
        logic [W-1:0] vec;
    } mstate_t;

    mstate_t m;
    logic    m_valid = 1'b0;

    // Reference: works on line indices, scanning for the highest-priority line.
    function automatic mstate_t model_next(input mstate_t s, input logic rst,
                                           input logic [N-1:0] in, input logic ack,
                                           input logic e, input logic wr,
                                           input logic [N-1:0] din);
        mstate_t      n;
        logic [N-1:0] emask;
        int           lo_isr;
        logic         ack_ok;
        logic         hit;
        n = '0;
        if (rst) return n;
        emask  = EdgeMask;
        n      = s;
        n.prev = in;
        ack_ok = s.req && ack;
        lo_isr = int'(N);
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (s.isr[i]) lo_isr = i;
        end
        for (int i = 0; i < int'(N); i++) begin
            hit = emask[i] ? (in[i] && !s.prev[i]) : in[i];
            if (hit) n.pend[i] = 1'b1;
            else if (ack_ok && i == int'(s.vec)) n.pend[i] = 1'b0;
        end
        if (e && lo_isr < int'(N)) n.isr[lo_isr] = 1'b0;
        if (ack_ok) n.isr[s.vec] = 1'b1;
        if (wr) n.en = din;
        if (!s.req) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (s.pend[i] && s.en[i] && i < lo_isr) begin
                    n.req = 1'b1;
                    n.vec = W'(i);
                end
            end
        end else if (ack_ok) begin
            n.req = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, reset, irq_in, irq_ack, eoi, en_wr, en_din);
        if (reset) m_valid <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model once it has seen a reset.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_req", 32'(irq_req), 32'(m.req));
            if (m.req) check("model_vec", 32'(irq_vec), 32'(m.vec));
            check("model_pending", 32'(pending), 32'(m.pend));
            check("model_in_service", 32'(in_service), 32'(m.isr));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [N-1:0] lines);
        irq_in = lines;
        cyc(1);
        irq_in = '0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        cyc(1);
        eoi = 1'b0;
    endtask

    task automatic write_en(input logic [N-1:0] v);
        en_wr  = 1'b1;
        en_din = v;
        cyc(1);
        en_wr  = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        irq_in  = '0;
        en_wr   = 1'b0;
        en_din  = '0;
        irq_ack = 1'b0;
        eoi     = 1'b0;
        cyc(3);
        check("rst_req", 32'(irq_req), 32'd0);
        check("rst_vec", 32'(irq_vec), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_in_service", 32'(in_service), 32'd0);
        reset = 1'b0;

        // Single edge on line 5
        write_en(8'hFF);
        pulse(8'h20);
        check("single_pending", 32'(pending), 32'h20);
        check("single_req_early", 32'(irq_req), 32'd0);
        cyc(1);
        check("single_req", 32'(irq_req), 32'd1);
        check("single_vec", 32'(irq_vec), 32'd5);
        do_ack();
        check("single_ack_isr", 32'(in_service), 32'h20);
        check("single_ack_pending", 32'(pending), 32'h00);
        check("single_ack_req", 32'(irq_req), 32'd0);
        do_eoi();
        check("single_eoi_isr", 32'(in_service), 32'h00);

        // Priority: lines 6 and 2 together
        pulse(8'h44);
        cyc(1);
        check("prio_vec_first", 32'(irq_vec), 32'd2);
        do_ack();
        check("prio_isr", 32'(in_service), 32'h04);
        check("prio_pending", 32'(pending), 32'h40);
        cyc(3);
        check("prio_blocked", 32'(irq_req), 32'd0);
        do_eoi();
        cyc(1);
        check("prio_second_req", 32'(irq_req), 32'd1);
        check("prio_second_vec", 32'(irq_vec), 32'd6);
        do_ack();
        do_eoi();

        // Nesting: line 4 in service, line 7 blocked, line 1 preempts
        pulse(8'h10);
        cyc(1);
        check("nest_vec4", 32'(irq_vec), 32'd4);
        do_ack();
        check("nest_isr4", 32'(in_service), 32'h10);
        pulse(8'h80);
        cyc(2);
        check("nest_7_blocked", 32'(irq_req), 32'd0);
        check("nest_7_pending", 32'(pending), 32'h80);
        pulse(8'h02);
        cyc(1);
        check("nest_vec1", 32'(irq_vec), 32'd1);
        check("nest_req1", 32'(irq_req), 32'd1);
        do_ack();
        check("nest_isr12", 32'(in_service), 32'h12);
        do_eoi();
        check("nest_eoi1", 32'(in_service), 32'h10);
        do_eoi();
        check("nest_eoi2", 32'(in_service), 32'h00);
        cyc(1);
        check("nest_vec7", 32'(irq_vec), 32'd7);
        do_ack();
        do_eoi();

        // Masking: line 2 disabled, then re-enabled
        write_en(8'hFB);
        pulse(8'h04);
        cyc(2);
        check("mask_no_req", 32'(irq_req), 32'd0);
        check("mask_pending", 32'(pending), 32'h04);
        write_en(8'hFF);
        cyc(1);
        check("mask_reenabled_req", 32'(irq_req), 32'd1);
        check("mask_reenabled_vec", 32'(irq_vec), 32'd2);
        do_ack();
        do_eoi();

        // Level line 3 held through ack and EOI
        irq_in = 8'h08;
        cyc(1);
        check("level_pending", 32'(pending), 32'h08);
        cyc(1);
        check("level_vec", 32'(irq_vec), 32'd3);
        do_ack();
        check("level_ack_pending", 32'(pending), 32'h08);
        check("level_ack_isr", 32'(in_service), 32'h08);
        cyc(2);
        check("level_blocked", 32'(irq_req), 32'd0);
        do_eoi();
        cyc(1);
        check("level_rereq", 32'(irq_req), 32'd1);
        check("level_revec", 32'(irq_vec), 32'd3);
        irq_in = '0;
        do_ack();
        do_eoi();

        // Ack coinciding with a new edge on the same line
        pulse(8'h20);
        cyc(1);
        irq_in  = 8'h20;
        irq_ack = 1'b1;
        cyc(1);
        irq_in  = '0;
        irq_ack = 1'b0;
        check("ack_edge_pending", 32'(pending), 32'h20);
        check("ack_edge_isr", 32'(in_service), 32'h20);
        do_eoi();
        cyc(1);
        check("ack_edge_rereq", 32'(irq_vec), 32'd5);
        do_ack();
        do_eoi();

        // EOI and ack in the same cycle
        pulse(8'h10);
        cyc(1);
        do_ack();
        pulse(8'h02);
        cyc(1);
        check("eoi_ack_vec", 32'(irq_vec), 32'd1);
        irq_ack = 1'b1;
        eoi     = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        eoi     = 1'b0;
        check("eoi_ack_isr", 32'(in_service), 32'h02);
        do_eoi();

        // Ack while idle
        do_ack();
        check("idle_ack_req", 32'(irq_req), 32'd0);
        check("idle_ack_isr", 32'(in_service), 32'h00);
        check("idle_ack_pending", 32'(pending), 32'h00);

        // Reset during handshake
        pulse(8'h40);
        cyc(1);
        check("pre_reset_req", 32'(irq_req), 32'd1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("mid_reset_req", 32'(irq_req), 32'd0);
        check("mid_reset_vec", 32'(irq_vec), 32'd0);
        check("mid_reset_pending", 32'(pending), 32'd0);
        check("mid_reset_isr", 32'(in_service), 32'd0);

        // Randomized traffic against the model
        write_en(8'hFF);
        for (int c = 0; c < 4000; c++) begin
            irq_in  = N'($urandom & $urandom & $urandom);
            irq_ack = 1'($urandom_range(0, 1));
            eoi     = ($urandom_range(0, 3) == 0);
            en_wr   = ($urandom_range(0, 15) == 0);
            en_din  = N'($urandom | $urandom);
            reset   = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        irq_in  = '0;
        irq_ack = 1'b0;
        eoi     = 1'b0;
        en_wr   = 1'b0;
        reset   = 1'b0;
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
